// File: rtl/uart_tx_fifo_cfg_if.sv
// Byte-stream handshake into the UART transmitter FIFO.
// The master offers data with valid; the slave accepts it when ready.
interface uart_tx_fifo_cfg_if #(
  parameter int DATA_W = 8
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/uart_tx_fifo_cfg.sv
// Configurable UART transmitter (5..9 data bits, optional parity, 1/2 stop bits)
// with a runtime baud divisor and a small FIFO in front of the shifter.
module uart_tx_fifo_cfg #(
  parameter int CLOCK_HZ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_W     = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  uart_tx_fifo_cfg_if.slave           s_if,
  input  logic [15:0]                 i_div,
  output logic                        o_uart_tx,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_level
);
  localparam int DEF_DIV = CLOCK_HZ / BAUD_RATE;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int BW      = $clog2(DATA_W);

  localparam logic [15:0]   DEF_DIV16 = 16'(DEF_DIV);
  localparam logic [AW:0]   FULL_LVL  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_fifo_cfg: DATA_W must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo_cfg: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo_cfg: FIFO_DEPTH must be a power of two >= 2");
  end
  if (DEF_DIV < 1 || DEF_DIV > 65535) begin : g_bad_div
    $error("uart_tx_fifo_cfg: CLOCK_HZ/BAUD_RATE must be 1..65535");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] shift_q, head;
  logic              par_q, tx_q, busy_q;
  logic [15:0]       div_q, baud_cnt_q, div_sel;
  logic [BW-1:0]     bit_idx_q;
  logic              stop_idx_q;
  logic              push, pop, bit_end, frame_end, going_idle;

  assign head       = mem_q[rd_ptr_q];
  assign div_sel    = (i_div == 16'd0) ? DEF_DIV16 : i_div;
  assign s_if.ready = (count_q != FULL_LVL);
  assign push       = s_if.valid && s_if.ready;
  assign bit_end    = (baud_cnt_q == div_q - 16'd1);
  assign frame_end  = (state_q == STOP) && bit_end && (stop_idx_q == LAST_STOP);
  // A pop starts a frame, either from idle or back-to-back after the last stop bit.
  assign pop        = (count_q != '0) && ((state_q == IDLE) || frame_end);
  assign going_idle = (count_q == '0) && ((state_q == IDLE) || frame_end);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= s_if.data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      div_q      <= DEF_DIV16;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
    end else begin
      busy_q <= !going_idle || (count_d != '0);
      if (pop) begin
        state_q    <= START;
        tx_q       <= 1'b0;
        shift_q    <= head;
        par_q      <= (PARITY == 1) ? ^head : ~^head;
        div_q      <= div_sel;
        baud_cnt_q <= '0;
      end else begin
        baud_cnt_q <= bit_end ? 16'd0 : baud_cnt_q + 16'd1;
        case (state_q)
          IDLE: begin
            tx_q       <= 1'b1;
            baud_cnt_q <= '0;
          end
          START: if (bit_end) begin
            state_q   <= DATA;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_idx_q <= '0;
          end
          DATA: if (bit_end) begin
            if (bit_idx_q == LAST_BIT) begin
              stop_idx_q <= 1'b0;
              if (PARITY != 0) begin
                state_q <= PAR;
                tx_q    <= par_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + BW'(1);
            end
          end
          PAR: if (bit_end) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
          STOP: if (bit_end) begin
            if (stop_idx_q == LAST_STOP) state_q <= IDLE;
            else                         stop_idx_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_uart_tx = tx_q;
  assign o_busy    = busy_q;
  assign o_level   = count_q;
endmodule
